// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
// alu_sequencer_pkg
// Encodings, decode helpers and PSR update mask for the multi-cycle ALU sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_sequencer_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_XOR = 4'b0011,
    ALU_OR   = 4'b0100, ALU_CMP = 4'b0101, ALU_MOV = 4'b0110, ALU_LSH = 4'b0111,
    ALU_LSHI = 4'b1000, ALU_LUI = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM_RD = 3'd3,
    S_MEM_WB = 3'd4, S_MEM_WR = 3'd5, S_BRANCH = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_EXEC = 3'd0, CLS_LOAD = 3'd1, CLS_STOR = 3'd2, CLS_BRANCH = 3'd3, CLS_ILLEGAL = 3'd4
  } op_class_e;

  typedef struct packed {
    op_class_e cls;
    alu_op_e   op;
    logic      imm_sel;
    logic      jump;
  } decode_t;

  // Immediate opcodes reuse the R-type extension code of the same operation.
  localparam logic [3:0] CODE_AND  = 4'h1, CODE_OR   = 4'h2, CODE_XOR = 4'h3;
  localparam logic [3:0] CODE_ADD  = 4'h5, CODE_ADDU = 4'h6, CODE_ADDC = 4'h7;
  localparam logic [3:0] CODE_SUB  = 4'h9, CODE_SUBC = 4'hA, CODE_CMP = 4'hB;
  localparam logic [3:0] CODE_MOV  = 4'hD;

  localparam logic [3:0] OP_RTYPE = 4'h0, OP_MEM = 4'h4, OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_BCOND = 4'hC, OP_LUI = 4'hF;
  localparam logic [3:0] EXT_LOAD = 4'h0, EXT_STOR = 4'h4, EXT_JCOND = 4'hC, EXT_LSH = 4'h4;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4, COND_LS = 4'h5, COND_GT = 4'h6, COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8, COND_FC = 4'h9, COND_LO = 4'hA, COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC, COND_GE = 4'hD, COND_UC = 4'hE, COND_NV = 4'hF;

  localparam int PSR_C = 0, PSR_F = 1, PSR_L = 2, PSR_Z = 3, PSR_N = 4;

  function automatic logic arith_valid(input logic [3:0] code);
    case (code)
      CODE_AND, CODE_OR, CODE_XOR, CODE_ADD, CODE_ADDU, CODE_ADDC,
      CODE_SUB, CODE_SUBC, CODE_CMP, CODE_MOV: arith_valid = 1'b1;
      default:                                 arith_valid = 1'b0;
    endcase
  endfunction

  // Carry/unsigned variants share the plain ADD/SUB datapath operation.
  function automatic alu_op_e arith_op(input logic [3:0] code);
    case (code)
      CODE_AND:            arith_op = ALU_AND;
      CODE_OR:             arith_op = ALU_OR;
      CODE_XOR:            arith_op = ALU_XOR;
      CODE_SUB, CODE_SUBC: arith_op = ALU_SUB;
      CODE_CMP:            arith_op = ALU_CMP;
      CODE_MOV:            arith_op = ALU_MOV;
      default:             arith_op = ALU_ADD;
    endcase
  endfunction

  function automatic decode_t decode(input logic [15:0] ir);
    decode_t d;
    d.cls     = CLS_ILLEGAL;
    d.op      = ALU_ADD;
    d.imm_sel = 1'b0;
    d.jump    = 1'b0;
    case (ir[15:12])
      OP_RTYPE: if (arith_valid(ir[7:4])) begin
        d.cls = CLS_EXEC;
        d.op  = arith_op(ir[7:4]);
      end
      OP_MEM: case (ir[7:4])
        EXT_LOAD:  d.cls = CLS_LOAD;
        EXT_STOR:  d.cls = CLS_STOR;
        EXT_JCOND: begin d.cls = CLS_BRANCH; d.jump = 1'b1; end
        default:   d.cls = CLS_ILLEGAL;
      endcase
      OP_SHIFT: if (ir[7:4] == EXT_LSH) begin
        d.cls = CLS_EXEC;
        d.op  = ALU_LSH;
      end else if (ir[7:5] == 3'b000) begin
        d.cls     = CLS_EXEC;
        d.op      = ALU_LSHI;
        d.imm_sel = 1'b1;
      end
      OP_BCOND: d.cls = CLS_BRANCH;
      OP_LUI: begin
        d.cls     = CLS_EXEC;
        d.op      = ALU_LUI;
        d.imm_sel = 1'b1;
      end
      default: if (arith_valid(ir[15:12])) begin
        d.cls     = CLS_EXEC;
        d.op      = arith_op(ir[15:12]);
        d.imm_sel = 1'b1;
      end
    endcase
    return d;
  endfunction

  function automatic logic [4:0] psr_mask(input alu_op_e op);
    case (op)
      ALU_ADD, ALU_SUB: psr_mask = 5'b00011;
      ALU_CMP:          psr_mask = 5'b11100;
      default:          psr_mask = 5'b00000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_cond_eval.sv
// ============================================================================
// alu_sequencer_cond_eval
// Combinational branch-condition evaluator: 4-bit condition + PSR -> take.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_sequencer_cond_eval
  import alu_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] psr,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_EQ: take =  psr[PSR_Z];
      COND_NE: take = ~psr[PSR_Z];
      COND_CS: take =  psr[PSR_C];
      COND_CC: take = ~psr[PSR_C];
      COND_HI: take =  psr[PSR_L];
      COND_LS: take = ~psr[PSR_L];
      COND_GT: take =  psr[PSR_N];
      COND_LE: take = ~psr[PSR_N];
      COND_FS: take =  psr[PSR_F];
      COND_FC: take = ~psr[PSR_F];
      COND_LO: take = ~psr[PSR_L] & ~psr[PSR_Z];
      COND_HS: take =  psr[PSR_L] |  psr[PSR_Z];
      COND_LT: take = ~psr[PSR_N] & ~psr[PSR_Z];
      COND_GE: take =  psr[PSR_N] |  psr[PSR_Z];
      COND_UC: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer
// Multi-cycle control FSM for the 16-bit ALU datapath; owns IR and latched PSR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PSR_BITS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    mem_rdata,
  input  logic                mem_ready,
  input  logic [PSR_BITS-1:0] alu_psr,
  output logic [3:0]          alucont,
  output logic [3:0]          rdest_sel,
  output logic [3:0]          rsrc_sel,
  output logic [7:0]          imm,
  output logic                imm_sel,
  output logic                reg_we,
  output logic                wb_sel,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic [PSR_BITS-1:0] psr,
  output logic                illegal_op
);

  state_e             state, next_state;
  logic [WIDTH-1:0]   ir;
  decode_t            dec;
  logic               take;
  logic [PSR_BITS-1:0] mask;

  assign dec       = decode(ir);
  assign mask      = psr_mask(dec.op);
  assign rdest_sel = ir[11:8];
  assign rsrc_sel  = ir[3:0];
  assign imm       = ir[7:0];

  alu_sequencer_cond_eval u_cond_eval (
    .cond (ir[11:8]),
    .psr  (psr),
    .take (take)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
      ir    <= '0;
      psr   <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH && mem_ready) ir <= mem_rdata;
      if (state == S_EXEC) psr <= (psr & ~mask) | (alu_psr & mask);
    end
  end

  // Outputs are forced quiet while reset is held, even though the state is FETCH.
  always_comb begin
    next_state = state;
    alucont    = ALU_ADD;
    imm_sel    = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'd0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    illegal_op = 1'b0;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            pc_en      = 1'b1;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          case (dec.cls)
            CLS_EXEC:   next_state = S_EXEC;
            CLS_LOAD:   next_state = S_MEM_RD;
            CLS_STOR:   next_state = S_MEM_WR;
            CLS_BRANCH: next_state = S_BRANCH;
            default: begin
              illegal_op = 1'b1;
              next_state = S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          alucont    = dec.op;
          imm_sel    = dec.imm_sel;
          reg_we     = (dec.op != ALU_CMP);
          next_state = S_FETCH;
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready) next_state = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_we     = 1'b1;
          wb_sel     = 1'b1;
          next_state = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready) next_state = S_FETCH;
        end
        S_BRANCH: begin
          if (take) begin
            pc_en  = 1'b1;
            pc_src = dec.jump ? 2'd2 : 2'd1;
          end
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire
